// File: rtl/pwm_bank_pkg.sv
// Shared types, constants and the duty conditioning helper for the PWM channel bank.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package pwm_bank_pkg;

    // Default duty / period counter width. Modules take WIDTH as a parameter and
    // derive their own limits from it.
    localparam int PWM_WIDTH  = 10;
    // Last value of the period counter before it wraps (period = 2^WIDTH-1 ticks).
    localparam int PERIOD_MAX = (1 << PWM_WIDTH) - 2;
    // Duty value that keeps an output permanently high.
    localparam int DUTY_FULL  = (1 << PWM_WIDTH) - 1;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    // Saturate an offset-adjusted raw duty and map it onto 0..2^width-1.
    // Signed inputs are reduced to their magnitude and doubled, so the full
    // positive or negative range covers the whole PWM period. The final clamp
    // catches the one case that overflows: the most negative value.
    function automatic int sat_abs_scale(input int v, input int width, input bit signedIn);
        int lo;
        int hi;
        int d;
        if (signedIn) begin
            lo = -(1 << (width - 1));
            hi = (1 << (width - 1)) - 1;
        end else begin
            lo = 0;
            hi = (1 << width) - 1;
        end
        d = (v < lo) ? lo : ((v > hi) ? hi : v);
        if (signedIn) begin
            d = ((d < 0) ? -d : d) << 1;
        end
        if (d > (1 << width) - 1) begin
            d = (1 << width) - 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/pwm_duty_conditioner.sv
// Per-channel duty conditioning: add offset, saturate, take magnitude and scale.
// Latency: purely combinational.
// Backpressure: none; the result is sampled by the bank only on load.
//
// Ports:
//   dutyRaw   in   WIDTH  raw duty word (two's complement when SIGNED_IN=1)
//   dutyCond  out  WIDTH  conditioned duty in 0..2^WIDTH-1
module pwm_duty_conditioner
    import pwm_bank_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int OFFSET    = 0,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic [WIDTH-1:0] dutyRaw,
    output logic [WIDTH-1:0] dutyCond
);

    // Two spare bits keep raw + OFFSET from wrapping before saturation.
    logic signed [WIDTH+1:0] rawExt;
    logic signed [WIDTH+1:0] offsetExt;
    logic signed [WIDTH+1:0] sum;

    always_comb begin
        rawExt    = SIGNED_IN ? {{2{dutyRaw[WIDTH-1]}}, dutyRaw} : {2'b00, dutyRaw};
        offsetExt = (WIDTH+2)'(OFFSET);
        sum       = rawExt + offsetExt;
        dutyCond  = WIDTH'(sat_abs_scale(int'(sum), WIDTH, SIGNED_IN));
    end

endmodule

// File: rtl/pwm_channel_bank.sv
// N-channel PWM bank with a shared prescaled period counter and double-buffered duties.
// Latency: pwm_out/period_start/update_ack are registered, one cycle behind the counter.
// Backpressure: none; load is always accepted, duties apply at the next period wrap.
//
// Ports:
//   CLOCK_50      in   1             system clock
//   RESET         in   1             asynchronous, active-high reset
//   enable        in   1             0 freezes prescaler and counter and forces pwm_out low
//   load          in   1             strobe capturing every duty_in channel into the shadow regs
//   duty_in       in   NUM_CH*WIDTH  packed raw duties, channel k at [k*WIDTH +: WIDTH]
//   pwm_out       out  NUM_CH        registered PWM outputs
//   period_start  out  1             pulse on the cycle after the counter wraps
//   update_ack    out  1             pulse on the cycle after new duties become active
module pwm_channel_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int WIDTH     = PWM_WIDTH,
    parameter int PRESCALE  = 1,
    parameter int OFFSET    = 0,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    enable,
    input  logic                    load,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    update_ack
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

    logic [PRE_W-1:0] preCnt;
    logic [WIDTH-1:0] periodCnt;
    logic             tick;
    logic             wrap;
    logic             pending;

    logic [WIDTH-1:0] condDuty   [NUM_CH];
    logic [WIDTH-1:0] shadowDuty [NUM_CH];
    logic [WIDTH-1:0] activeDuty [NUM_CH];

    // ------------------------------------------------------------------
    // Conditioning, one instance per channel
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : genCond
        pwm_duty_conditioner #(
            .WIDTH     (WIDTH),
            .OFFSET    (OFFSET),
            .SIGNED_IN (SIGNED_IN)
        ) uCond (
            .dutyRaw  (duty_in[k*WIDTH +: WIDTH]),
            .dutyCond (condDuty[k])
        );
    end

    // ------------------------------------------------------------------
    // Timebase: prescaler and period counter, both frozen while disabled
    // ------------------------------------------------------------------
    assign tick = enable && (preCnt == PRE_LAST);
    assign wrap = tick && (periodCnt == CNT_LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            preCnt <= '0;
        end else if (enable) begin
            preCnt <= (preCnt == PRE_LAST) ? '0 : preCnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            periodCnt <= '0;
        end else if (tick) begin
            periodCnt <= wrap ? '0 : periodCnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load that lands on the wrap cycle bypasses the
    // shadow so the new duties are not held back a whole extra period.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadowDuty[k] <= '0;
                activeDuty[k] <= '0;
            end
            pending    <= 1'b0;
            update_ack <= 1'b0;
        end else begin
            update_ack <= wrap && (pending || load);

            if (load) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    shadowDuty[k] <= condDuty[k];
                end
            end

            if (wrap && load) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    activeDuty[k] <= condDuty[k];
                end
            end else if (wrap && pending) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    activeDuty[k] <= shadowDuty[k];
                end
            end

            if (wrap) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comparators. Counter tops out at 2^WIDTH-2, so a full-scale duty
    // keeps the output high and zero keeps it low.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            for (int k = 0; k < NUM_CH; k++) begin
                pwm_out[k] <= enable && (periodCnt < activeDuty[k]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
module tb_pwm_channel_bank;

    localparam int NCH    = 8;
    localparam int W      = 10;
    localparam int PERIOD = (1 << W) - 1;   // ticks per PWM period
    localparam int PRE_C  = 4;              // prescale of the third instance

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: unsigned, no prescale. 1: signed. 2: signed, OFFSET=10, PRESCALE=4.
    logic             rstI  [3];
    logic             enI   [3];
    logic             ldI   [3];
    logic [NCH*W-1:0] dutyI [3];
    logic [NCH-1:0]   pwmI  [3];
    logic             psI   [3];
    logic             ackI  [3];

    pwm_channel_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1), .OFFSET(0), .SIGNED_IN(1'b0)) dutU (
        .CLOCK_50(clk), .RESET(rstI[0]), .enable(enI[0]), .load(ldI[0]), .duty_in(dutyI[0]),
        .pwm_out(pwmI[0]), .period_start(psI[0]), .update_ack(ackI[0]));

    pwm_channel_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1), .OFFSET(0), .SIGNED_IN(1'b1)) dutS (
        .CLOCK_50(clk), .RESET(rstI[1]), .enable(enI[1]), .load(ldI[1]), .duty_in(dutyI[1]),
        .pwm_out(pwmI[1]), .period_start(psI[1]), .update_ack(ackI[1]));

    pwm_channel_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(PRE_C), .OFFSET(10), .SIGNED_IN(1'b1)) dutP (
        .CLOCK_50(clk), .RESET(rstI[2]), .enable(enI[2]), .load(ldI[2]), .duty_in(dutyI[2]),
        .pwm_out(pwmI[2]), .period_start(psI[2]), .update_ack(ackI[2]));

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Period monitor: high cycles per channel between period_start pulses.
    int acc      [3][NCH];
    int meas     [3][NCH];
    int psCount  [3];
    int ackCount [3];
    int psLast   [3];
    int psPrev   [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < NCH; k++) begin
                acc[i][k] = acc[i][k] + (pwmI[i][k] ? 1 : 0);
            end
            if (psI[i]) begin
                for (int k = 0; k < NCH; k++) begin
                    meas[i][k] = acc[i][k];
                    acc[i][k]  = 0;
                end
                psCount[i] = psCount[i] + 1;
                psPrev[i]  = psLast[i];
                psLast[i]  = cyc;
            end
            if (ackI[i]) ackCount[i] = ackCount[i] + 1;
        end
    end

    typedef struct {
        int inst;
        int raw  [NCH];
        int expd [NCH];
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int preOf(input int i);
        return (i == 2) ? PRE_C : 1;
    endfunction

    // Reference conditioning, straight from the arithmetic rules.
    function automatic int refDuty(input int raw, input bit sgn, input int off);
        int v;
        int d;
        v = (sgn && raw >= 512) ? raw - 1024 : raw;
        v = v + off;
        if (sgn) begin
            if (v < -512) v = -512;
            if (v > 511) v = 511;
            d = 2 * ((v < 0) ? -v : v);
        end else begin
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            d = v;
        end
        return (d > 1023) ? 1023 : d;
    endfunction

    function automatic int pickRaw();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 511;
            2: return 512;
            3: return 1023;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitPs(input int i, input int n);
        int target;
        int budget;
        target = psCount[i] + n;
        budget = n * (PRE_C * PERIOD + 100);
        while (psCount[i] < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (psCount[i] < target) check($sformatf("inst%0d period_start timeout", i), psCount[i], target);
    endtask

    task automatic waitUntilCyc(input int t);
        int budget;
        budget = 5000;
        while (cyc < t && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (cyc != t) check("cycle alignment", cyc, t);
    endtask

    task automatic setDuty(input int i, input int raw [NCH]);
        for (int k = 0; k < NCH; k++) dutyI[i][k*W +: W] = W'(raw[k]);
    endtask

    task automatic loadAll(input int i, input int raw [NCH]);
        setDuty(i, raw);
        ldI[i] = 1'b1;
        @(posedge clk); #1;
        ldI[i] = 1'b0;
    endtask

    task automatic loadFlat(input int i, input int val);
        int raw [NCH];
        for (int k = 0; k < NCH; k++) raw[k] = val;
        loadAll(i, raw);
    endtask

    task automatic applyVec(input int v);
        int i;
        int a0;
        i = tbl[v].inst;
        loadAll(i, tbl[v].raw);
        a0 = ackCount[i];
        waitPs(i, 2);
        for (int k = 0; k < NCH; k++)
            check($sformatf("vec%0d ch%0d high cycles", v, k), meas[i][k], tbl[v].expd[k] * preOf(i));
        check($sformatf("vec%0d update_ack count", v), ackCount[i] - a0, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int w;
        int bad;
        int acks;
        int rawU [NCH];
        int rawS [NCH];

        for (int i = 0; i < 3; i++) begin
            rstI[i] = 1'b1; enI[i] = 1'b0; ldI[i] = 1'b0; dutyI[i] = '0;
        end

        tbl[0].inst = 0; tbl[0].raw = '{512, 0, 1023, 1, 1022, 100, 700, 5};
        tbl[0].expd = '{512, 0, 1023, 1, 1022, 100, 700, 5};
        tbl[1].inst = 0; tbl[1].raw = '{0, 1023, 1, 2, 511, 513, 1000, 23};
        tbl[1].expd = '{0, 1023, 1, 2, 511, 513, 1000, 23};
        tbl[2].inst = 1; tbl[2].raw = '{'h300, 255, 'h200, 0, 1, 'h3FF, 511, 'h201};
        tbl[2].expd = '{512, 510, 1023, 0, 2, 2, 1022, 1022};
        tbl[3].inst = 1; tbl[3].raw = '{100, 'h39C, 300, 'h2D4, 'h3FE, 2, 510, 'h202};
        tbl[3].expd = '{200, 200, 600, 600, 4, 4, 1020, 1020};
        tbl[4].inst = 2; tbl[4].raw = '{505, 'h3F6, 0, 'h3F5, 500, 'h200, 'h205, 511};
        tbl[4].expd = '{1022, 0, 20, 2, 1020, 1004, 994, 1022};

        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("inst%0d outputs in reset", i), int'({pwmI[i], psI[i], ackI[i]}), 0);
        for (int i = 0; i < 3; i++) rstI[i] = 1'b0;
        waitCycles(2);
        for (int i = 0; i < 3; i++) enI[i] = 1'b1;

        fork
            begin
                for (int v = 0; v < 5; v++) if (tbl[v].inst != 2) applyVec(v);

                // Random duties on the unsigned and signed banks in lockstep.
                for (int r = 0; r < 4; r++) begin
                    for (int k = 0; k < NCH; k++) begin
                        rawU[k] = pickRaw();
                        rawS[k] = pickRaw();
                    end
                    fork
                        loadAll(0, rawU);
                        loadAll(1, rawS);
                    join
                    fork
                        waitPs(0, 2);
                        waitPs(1, 2);
                    join
                    for (int k = 0; k < NCH; k++) begin
                        check($sformatf("rand%0d unsigned ch%0d raw %0d", r, k, rawU[k]),
                              meas[0][k], refDuty(rawU[k], 1'b0, 0));
                        check($sformatf("rand%0d signed ch%0d raw %0d", r, k, rawS[k]),
                              meas[1][k], refDuty(rawS[k], 1'b1, 0));
                    end
                end

                // Two loads in one period: old value holds, last write wins, one ack.
                loadFlat(0, 200);
                waitPs(0, 2);
                check("baseline duty 200", meas[0][0], 200);
                waitCycles(100);
                loadFlat(0, 300);
                a0 = ackCount[0];
                waitCycles(200);
                loadFlat(0, 700);
                waitPs(0, 1);
                check("duty held until wrap", meas[0][0], 200);
                waitPs(0, 1);
                check("last write wins ch0", meas[0][0], 700);
                check("last write wins ch6", meas[0][6], 700);
                check("double load single ack", ackCount[0] - a0, 1);

                // Load landing exactly on the wrap edge goes straight to active.
                waitPs(0, 1);
                w = psLast[0];
                waitUntilCyc(w + PERIOD - 1);
                loadFlat(0, 100);
                check("wrap-edge load period_start", int'(psI[0]), 1);
                check("wrap-edge load update_ack", int'(ackI[0]), 1);
                a0 = ackCount[0];
                waitPs(0, 2);
                check("wrap-edge load ch0", meas[0][0], 100);
                check("wrap-edge load ch5", meas[0][5], 100);
                check("wrap-edge load leaves nothing pending", ackCount[0] - a0, 1);

                // Asynchronous reset mid-period with an update pending.
                waitPs(0, 1);
                waitCycles(10);
                loadFlat(0, 900);
                waitCycles(5);
                check("pwm high before reset", int'(pwmI[0]), 255);
                #3 rstI[0] = 1'b1;
                #1;
                check("async reset clears outputs", int'({pwmI[0], psI[0], ackI[0]}), 0);
                repeat (3) @(posedge clk);
                #1 rstI[0] = 1'b0;
                bad = 0;
                acks = 0;
                for (int j = 0; j < 2 * PERIOD + 20; j++) begin
                    @(posedge clk); #1;
                    if (pwmI[0] != '0) bad++;
                    if (ackI[0]) acks++;
                end
                check("pwm low after reset", bad, 0);
                check("pending lost across reset", acks, 0);
                loadFlat(0, 50);
                a0 = ackCount[0];
                waitPs(0, 2);
                check("recovery duty ch0", meas[0][0], 50);
                check("recovery duty ch7", meas[0][7], 50);
                check("recovery update_ack", ackCount[0] - a0, 1);
            end
            begin
                applyVec(4);
                waitPs(2, 1);
                check("prescaled period spacing", psLast[2] - psPrev[2], PRE_C * PERIOD);
                waitCycles(2000);
                check("ch0 high before disable", int'(pwmI[2][0]), 1);
                enI[2] = 1'b0;
                bad = 0;
                repeat (50) begin
                    @(posedge clk); #1;
                    if (pwmI[2] != '0) bad++;
                end
                enI[2] = 1'b1;
                check("pwm forced low while disabled", bad, 0);
                waitPs(2, 1);
                check("period stretched by disable", psLast[2] - psPrev[2], PRE_C * PERIOD + 50);
                waitPs(2, 1);
                check("spacing after re-enable", psLast[2] - psPrev[2], PRE_C * PERIOD);
                check("duty after re-enable ch0", meas[2][0], PRE_C * 1022);
                check("duty after re-enable ch5", meas[2][5], PRE_C * 1004);
            end
        join

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
